display_ctrl: RTL

Front-end controller for the 8-digit 7-segment scanner. It arbitrates between two sources: a persistent CPU MMIO value, and a transient status/error message shown for a fixed hold time before the CPU value returns. It drives the scanner's 32-bit nibble-encoded data word (digit 7 = bits[31:28], digit 0 = bits[3:0]). Optionally it renders the CPU value in decimal through a sequential binary-to-BCD converter.

---
 rtl/display_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/display_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display front-end controller.
// Optional decimal rendering is enabled with the DISP_DEC_EN macro.
package display_pkg;

    typedef enum logic [1:0] {
        SHOW_CPU = 2'd0,
        CONVERT  = 2'd1,
        SHOW_MSG = 2'd2
    } disp_state_e;

    localparam int          DIGITS         = 8;
    localparam logic [31:0] DEC_MAX        = 32'd99_999_999;
    localparam logic [3:0]  OVF_NIBBLE     = 4'hE;
    localparam int          CLK_PER_MS_DEF = 100000;

    // Pattern shown when the value does not fit in eight decimal digits
    function automatic logic [31:0] ovf_word();
        return {DIGITS{OVF_NIBBLE}};
    endfunction

    function automatic logic is_ovf(input logic [31:0] value);
        return value > DEC_MAX;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 8 packed BCD digits,
// one shift per cycle. A start while busy reloads and restarts.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd,
    output logic        ovf
);

    logic [31:0] bin_q;
    logic [31:0] bcd_q;
    logic [31:0] adj;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        ovf_q;

    // Add-3 correction on every digit that is 5 or more before each shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? bcd_q[4*g +: 4] + 4'd3
                                                         : bcd_q[4*g +: 4];
    end

    // Load on start, then 32 shift steps; done pulses after the last one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (start) begin
            bin_q  <= value;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            ovf_q  <= is_ovf(value);
        end else if (busy_q) begin
            bcd_q  <= {adj[30:0], bin_q[31]};
            bin_q  <= {bin_q[30:0], 1'b0};
            cnt_q  <= cnt_q + 5'd1;
            done_q <= (cnt_q == 5'd31);
            busy_q <= (cnt_q != 5'd31);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/display_ctrl.sv
// Front-end for the 8-digit 7-segment scanner: shows the CPU value,
// pre-empted by timed status messages. Define DISP_DEC_EN to add
// decimal rendering of the CPU value through bin2bcd_seq.
module display_ctrl
    import display_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF,
    parameter int HOLD_MS    = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    input  logic        dec_mode,
    input  logic        msg_valid,
    input  logic [31:0] msg_data,
    output logic        msg_ready,
    output logic [31:0] data_out,
    output logic        busy
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MW = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);
    localparam logic [MW-1:0] MS_LAST   = MW'(HOLD_MS - 1);

    disp_state_e  state_q;
    logic [31:0]  data_q;
    logic [31:0]  cpu_reg_q;
    logic         busy_q;
    logic         dirty_q;
    logic [PW-1:0] presc_q;
    logic [MW-1:0] ms_q;

    logic         hs;
    logic         hold_done;
    logic [31:0]  cpu_cur;

    // Handshake, end-of-hold and freshest CPU value (a same-cycle write wins)
    always_comb begin
        hs        = msg_valid && (state_q == SHOW_CPU);
        hold_done = (state_q == SHOW_MSG) && (presc_q == PRESC_MAX) && (ms_q == MS_LAST);
        cpu_cur   = cpu_we ? cpu_wdata : cpu_reg_q;
    end

`ifdef DISP_DEC_EN
    logic        dec_q;
    logic        dec_rise;
    logic        dec_fall;
    logic        conv_start;
    logic        conv_done;
    logic        conv_ovf;
    logic [31:0] conv_bcd;
    logic        unused_conv_busy;

    // Decide when the converter must (re)load cpu_cur
    always_comb begin
        dec_rise   = dec_mode && !dec_q;
        dec_fall   = !dec_mode && dec_q;
        conv_start = 1'b0;
        case (state_q)
            SHOW_CPU: conv_start = !hs && ((cpu_we && dec_mode) || dec_rise);
            CONVERT:  conv_start = !dec_fall && cpu_we;
            SHOW_MSG: conv_start = hold_done && dec_mode;
            default:  conv_start = 1'b0;
        endcase
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .value (cpu_cur),
        .busy  (unused_conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );
`else
    logic unused_dec;
    assign unused_dec = dec_mode;
`endif

    // dirty records CPU writes hidden behind a message; kept for debug visibility
    logic unused_dirty;
    assign unused_dirty = dirty_q;

    // Main view FSM with registered data_out / busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SHOW_CPU;
            data_q    <= '0;
            cpu_reg_q <= '0;
            busy_q    <= 1'b0;
            dirty_q   <= 1'b0;
            presc_q   <= '0;
            ms_q      <= '0;
`ifdef DISP_DEC_EN
            dec_q     <= 1'b0;
`endif
        end else begin
            if (cpu_we) cpu_reg_q <= cpu_wdata;
`ifdef DISP_DEC_EN
            dec_q <= dec_mode;
`endif
            case (state_q)
                SHOW_CPU: begin
                    if (hs) begin
                        data_q  <= msg_data;
                        presc_q <= '0;
                        ms_q    <= '0;
                        state_q <= SHOW_MSG;
                    end
`ifdef DISP_DEC_EN
                    else if (conv_start) begin
                        state_q <= CONVERT;
                        busy_q  <= 1'b1;
                    end
`endif
                    else if (cpu_we) begin
                        data_q <= cpu_wdata;
                    end
`ifdef DISP_DEC_EN
                    // Leaving decimal view: fall back to the hex word
                    else if (dec_fall) begin
                        data_q <= cpu_reg_q;
                    end
`endif
                end
                SHOW_MSG: begin
                    if (cpu_we) dirty_q <= 1'b1;
                    if (hold_done) begin
                        presc_q <= '0;
                        ms_q    <= '0;
                        dirty_q <= 1'b0;
`ifdef DISP_DEC_EN
                        if (dec_mode) begin
                            state_q <= CONVERT;
                            busy_q  <= 1'b1;
                        end else
`endif
                        begin
                            state_q <= SHOW_CPU;
                            data_q  <= cpu_cur;
                        end
                    end else if (presc_q == PRESC_MAX) begin
                        presc_q <= '0;
                        ms_q    <= ms_q + MW'(1);
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
`ifdef DISP_DEC_EN
                CONVERT: begin
                    if (dec_fall) begin
                        state_q <= SHOW_CPU;
                        busy_q  <= 1'b0;
                        data_q  <= cpu_cur;
                    end else if (conv_done && !cpu_we) begin
                        state_q <= SHOW_CPU;
                        busy_q  <= 1'b0;
                        data_q  <= conv_ovf ? ovf_word() : conv_bcd;
                    end
                end
`endif
                default: begin
                    state_q <= SHOW_CPU;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign msg_ready = (state_q == SHOW_CPU);
    assign data_out  = data_q;
    assign busy      = busy_q;

endmodule
